// File: rtl/norflash16_wb.sv
// Wishbone slave bridging 32-bit bus accesses onto a 16-bit parallel NOR flash.
// Each word is two halfword cycles, upper half (lower address) first.
`timescale 1ns/1ps
module norflash16_wb #(
    parameter int         ADR_WIDTH = 24,
    parameter logic [3:0] RD_TIMING = 4'd12,
    parameter logic [3:0] WR_TIMING = 4'd6
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [31:0]          wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    output logic [ADR_WIDTH-1:0] flash_adr,
    inout  wire  [15:0]          flash_d,
    output logic                 flash_oe_n,
    output logic                 flash_we_n,
    output logic                 flash_ce_n
);

    typedef enum logic [2:0] {
        IDLE, RD_HI, RD_LO, WR_SETUP, WR_PULSE, WR_HOLD, ACK
    } state_t;

    localparam int AW = ADR_WIDTH;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [AW-3:0]         adr_q, adr_d;
    logic [15:0]           wlo_q, wlo_d;
    logic                  lo_pend_q, lo_pend_d;
    logic [31:0]           dat_q, dat_d;
    logic                  ack_q, ack_d;
    logic [AW-1:0]         fadr_q, fadr_d;
    logic [15:0]           fd_q, fd_d;
    logic                  fd_oe_q, fd_oe_d;
    logic                  oe_n_q, oe_n_d;
    logic                  we_n_q, we_n_d;
    logic                  ce_n_q, ce_n_d;

    // Byte-lane and out-of-window address bits carry no meaning here.
    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[31:AW], wb_adr_i[1:0]};

    assign wb_dat_o   = dat_q;
    assign wb_ack_o   = ack_q;
    assign flash_adr  = fadr_q;
    assign flash_oe_n = oe_n_q;
    assign flash_we_n = we_n_q;
    assign flash_ce_n = ce_n_q;
    assign flash_d    = fd_oe_q ? fd_q : 16'hzzzz;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            adr_q     <= '0;
            wlo_q     <= 16'h0;
            lo_pend_q <= 1'b0;
            dat_q     <= 32'h0;
            ack_q     <= 1'b0;
            fadr_q    <= '0;
            fd_q      <= 16'h0;
            fd_oe_q   <= 1'b0;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            ce_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            wlo_q     <= wlo_d;
            lo_pend_q <= lo_pend_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
            fadr_q    <= fadr_d;
            fd_q      <= fd_d;
            fd_oe_q   <= fd_oe_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            ce_n_q    <= ce_n_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        wlo_d     = wlo_q;
        lo_pend_d = lo_pend_q;
        dat_d     = dat_q;
        ack_d     = 1'b0;
        fadr_d    = fadr_q;
        fd_d      = fd_q;
        fd_oe_d   = fd_oe_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        ce_n_d    = ce_n_q;
        unique case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    adr_d     = wb_adr_i[AW-1:2];
                    wlo_d     = wb_dat_i[15:0];
                    lo_pend_d = |wb_sel_i[1:0];
                    ce_n_d    = 1'b0;
                    if (!wb_we_i) begin
                        fadr_d  = {wb_adr_i[AW-1:2], 2'b00};
                        oe_n_d  = 1'b0;
                        cnt_d   = RD_TIMING;
                        state_d = RD_HI;
                    end else if (|wb_sel_i[3:2]) begin
                        fadr_d  = {wb_adr_i[AW-1:2], 2'b00};
                        fd_d    = wb_dat_i[31:16];
                        fd_oe_d = 1'b1;
                        state_d = WR_SETUP;
                    end else if (|wb_sel_i[1:0]) begin
                        fadr_d    = {wb_adr_i[AW-1:2], 2'b10};
                        fd_d      = wb_dat_i[15:0];
                        fd_oe_d   = 1'b1;
                        lo_pend_d = 1'b0;
                        state_d   = WR_SETUP;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end
                end
            end
            RD_HI: begin
                if (cnt_q == 4'd0) begin
                    dat_d[31:16] = flash_d;
                    fadr_d       = {adr_q, 2'b10};
                    cnt_d        = RD_TIMING;
                    state_d      = RD_LO;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_LO: begin
                if (cnt_q == 4'd0) begin
                    dat_d[15:0] = flash_d;
                    ack_d       = 1'b1;
                    state_d     = ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_SETUP: begin
                we_n_d  = 1'b0;
                cnt_d   = WR_TIMING;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == 4'd0) begin
                    we_n_d  = 1'b1;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_HOLD: begin
                if (lo_pend_q) begin
                    fadr_d    = {adr_q, 2'b10};
                    fd_d      = wlo_q;
                    lo_pend_d = 1'b0;
                    state_d   = WR_SETUP;
                end else begin
                    fd_oe_d = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                // Always returns to IDLE so back-to-back ops get a gap cycle.
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                fd_oe_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_norflash16_wb.sv
// Directed bench for norflash16_wb with a 16-bit NOR read model.
// Cycle 0 is the clock in which the request is first sampled.
`timescale 1ns/1ps
module tb_norflash16_wb;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [23:0] flash_adr;
    wire  [15:0] flash_d;
    logic        flash_oe_n;
    logic        flash_we_n;
    logic        flash_ce_n;

    int checks = 0;
    int errors = 0;

    norflash16_wb #(
        .ADR_WIDTH(24),
        .RD_TIMING(4'd2),
        .WR_TIMING(4'd1)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_sel_i   (wb_sel_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .flash_adr  (flash_adr),
        .flash_d    (flash_d),
        .flash_oe_n (flash_oe_n),
        .flash_we_n (flash_we_n),
        .flash_ce_n (flash_ce_n)
    );

    always #20 sys_clk = ~sys_clk;

    // Flash read model: output follows address/enables after 10 ns.
    logic [15:0] rom [0:15];
    logic        m_en = 1'b0;
    logic [15:0] m_dat = 16'h0;
    always @(flash_adr or flash_oe_n or flash_ce_n) begin
        #10;
        m_en  = !flash_ce_n && !flash_oe_n;
        m_dat = rom[flash_adr[4:1]];
    end
    assign flash_d = m_en ? m_dat : 16'hzzzz;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        checks++;
        assert (!(!flash_oe_n && !flash_we_n))
        else begin
            errors++;
            $error("FAIL oe_we_overlap: observed oe_n=%b we_n=%b expected not both 0",
                   flash_oe_n, flash_we_n);
        end
        checks++;
        assert (!(dut.fd_oe_q && !flash_oe_n))
        else begin
            errors++;
            $error("FAIL drive_while_oe: observed drive=1 oe_n=0 expected no drive");
        end
    end

    int          ack_cyc;
    logic [31:0] rd;
    logic [31:0] we_vec;
    logic [23:0] adr_tr [32];
    logic [15:0] d_tr [32];

    task automatic run_op(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel,
                          input bit hold, input bit early);
        @(negedge sys_clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        ack_cyc  = -1;
        we_vec   = '1;
        for (int c = 1; c < 32; c++) begin
            @(negedge sys_clk);
            if (early && c == 1) begin
                wb_cyc_i = 1'b0;
                wb_stb_i = 1'b0;
            end
            we_vec[c] = flash_we_n;
            adr_tr[c] = flash_adr;
            d_tr[c]   = flash_d;
            if (wb_ack_o) begin
                ack_cyc = c;
                rd      = wb_dat_o;
                if (!hold) begin
                    wb_cyc_i = 1'b0;
                    wb_stb_i = 1'b0;
                end
                break;
            end
        end
        if (ack_cyc < 0) begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
        end
    endtask

    initial begin
        int acks;
        rom[0] = 16'h1234; rom[1] = 16'h5678;
        rom[2] = 16'hA1B2; rom[3] = 16'hC3D4;
        rom[4] = 16'h0F1E; rom[5] = 16'h2D3C;
        for (int i = 6; i < 16; i++) rom[i] = 16'h0;
        sys_rst  = 1'b1;
        wb_adr_i = 32'h0;
        wb_dat_i = 32'h0;
        wb_sel_i = 4'h0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("reset_state",
            {wb_ack_o, wb_dat_o, flash_adr, flash_we_n, flash_oe_n, flash_ce_n},
            {1'b0, 32'h0, 24'h0, 3'b111});
        sys_rst = 1'b0;

        // Single read
        run_op(1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b0);
        chk("rd_ack_cyc", ack_cyc, 7);
        chk("rd_data", rd, 32'h12345678);
        chk("rd_adr_hi", {adr_tr[1], adr_tr[3]}, {24'h0, 24'h0});
        chk("rd_adr_lo", {adr_tr[4], adr_tr[6]}, {24'h2, 24'h2});
        @(negedge sys_clk);
        chk("rd_ack_once", wb_ack_o, 1'b0);

        // Back-to-back reads with strobe held through the ack
        run_op(1'b0, 32'h4, 32'h0, 4'hF, 1'b1, 1'b0);
        chk("b2b1_ack_cyc", ack_cyc, 7);
        chk("b2b1_data", rd, 32'hA1B2C3D4);
        chk("b2b1_adr", {adr_tr[1], adr_tr[4]}, {24'h4, 24'h6});
        wb_adr_i = 32'h8;
        run_op(1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 1'b0);
        chk("b2b2_ack_cyc", ack_cyc, 7);
        chk("b2b2_data", rd, 32'h0F1E2D3C);
        chk("b2b2_adr", {adr_tr[1], adr_tr[4]}, {24'h8, 24'hA});

        // Full word write
        run_op(1'b1, 32'h10, 32'hCAFEBABE, 4'hF, 1'b0, 1'b0);
        chk("wr_ack_cyc", ack_cyc, 9);
        chk("wr_we_trace", we_vec[9:1], 9'b110011001);
        chk("wr_hi", {adr_tr[2], d_tr[2]}, {24'h10, 16'hCAFE});
        chk("wr_lo", {adr_tr[6], d_tr[6]}, {24'h12, 16'hBABE});
        @(negedge sys_clk);
        chk("wr_release", {dut.fd_oe_q, wb_ack_o}, 2'b00);

        // Lower halfword only
        run_op(1'b1, 32'h20, 32'h11112222, 4'b0011, 1'b0, 1'b0);
        chk("wr_lo_ack_cyc", ack_cyc, 5);
        chk("wr_lo_we_trace", we_vec[5:1], 5'b11001);
        chk("wr_lo_pins", {adr_tr[2], d_tr[2]}, {24'h22, 16'h2222});

        // No byte selects: immediate ack, no strobe
        run_op(1'b1, 32'h30, 32'h33334444, 4'b0000, 1'b0, 1'b0);
        chk("wr_nosel_ack_cyc", ack_cyc, 1);
        chk("wr_nosel_we", we_vec[1], 1'b1);

        // Strobe dropped early still completes with one ack
        run_op(1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b1);
        chk("drop_ack_cyc", ack_cyc, 7);
        chk("drop_data", rd, 32'h12345678);
        @(negedge sys_clk);
        chk("drop_ack_once", wb_ack_o, 1'b0);

        // Reset during the write pulse
        @(negedge sys_clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 32'h10;
        wb_dat_i = 32'hCAFEBABE;
        wb_sel_i = 4'hF;
        repeat (2) @(negedge sys_clk);
        chk("rst_in_pulse", flash_we_n, 1'b0);
        sys_rst  = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(negedge sys_clk);
        chk("rst_abort",
            {flash_we_n, dut.fd_oe_q, wb_ack_o, flash_ce_n},
            4'b1001);
        sys_rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge sys_clk);
            if (wb_ack_o) acks++;
        end
        chk("rst_no_ack", acks, 0);
        run_op(1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b0);
        chk("rst_rd_ack_cyc", ack_cyc, 7);
        chk("rst_rd_data", rd, 32'h12345678);

        repeat (2) @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
